// File: rtl/dffram_rtl_param_if.sv
// Bus bundle for dffram_rtl_param: access request, read return and fill status.
// The master modport belongs to the bus adapter; the slave modport belongs to the RAM.
interface dffram_rtl_param_if #(
  parameter int NB      = 4,
  parameter int A_WIDTH = 11
);
  logic                EN;
  logic [NB-1:0]       WE;
  logic [A_WIDTH-1:0]  A;
  logic [8*NB-1:0]     Di;
  logic [8*NB-1:0]     Do;
  logic                VALID;
  logic                READY;
  logic                CLR;
  logic                PINJ;
  logic                PERR;

  modport master (
    output EN, WE, A, Di, CLR, PINJ,
    input  Do, VALID, READY, PERR
  );

  modport slave (
    input  EN, WE, A, Di, CLR, PINJ,
    output Do, VALID, READY, PERR
  );
endinterface

// File: rtl/dffram_rtl_param.sv
// Parametrised single-port byte-write DFF RAM with post-reset zero-fill, optional output
// register and selectable read-during-write. Define PARITY_EN for per-byte even parity.
//
// state  | meaning
// S_FILL | zero-fill engine writes word[cnt]; accesses ignored, READY=0
// S_RUN  | array accepts accesses, READY=1
module dffram_rtl_param #(
  parameter int WORDS    = 2048,
  parameter int NB       = 4,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  dffram_rtl_param_if.slave      bus
);
  localparam int DW      = 8 * NB;
  localparam int A_WIDTH = $clog2(WORDS);
  localparam logic [A_WIDTH-1:0] CNT_LAST = A_WIDTH'(WORDS - 1);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;

  logic [DW-1:0] mem [WORDS];

  logic          ready;
  logic          access;
  logic          in_range;
  logic          wr_en;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] merged;
  logic [DW-1:0] d1_d, d1_q;
  logic          v1_d, v1_q;
  logic          p1_d, p1_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FILL: begin
        if (bus.CLR) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.CLR) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready    = (state_q == S_RUN);
  assign access   = ready & bus.EN;
  assign in_range = (32'(bus.A) < 32'(WORDS));
  assign wr_en    = access & in_range;

  // Out-of-range addresses (non-power-of-two depth) read as zero and never touch the array.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[bus.A];
  end

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (bus.WE[i]) merged[8*i +: 8] = bus.Di[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_FILL) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.WE[i]) mem[bus.A][8*i +: 8] <= bus.Di[8*i +: 8];
      end
    end
  end

`ifdef PARITY_EN
  logic [NB-1:0] par_mem [WORDS];
  logic [NB-1:0] rd_par, rd_bad, out_bad, wr_par;

  always_comb begin
    rd_par = '0;
    if (in_range) rd_par = par_mem[bus.A];
    for (int i = 0; i < NB; i++) begin
      wr_par[i]  = (^bus.Di[8*i +: 8]) ^ bus.PINJ;
      rd_bad[i]  = rd_par[i] ^ (^rd_word[8*i +: 8]);
      out_bad[i] = ((RDW_MODE != 0) && bus.WE[i]) ? bus.PINJ : rd_bad[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_FILL) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.WE[i]) par_mem[bus.A][i] <= wr_par[i];
      end
    end
  end

  assign p1_d = wr_en & (|out_bad);
`else
  logic unused_pinj;
  assign unused_pinj = bus.PINJ;
  assign p1_d        = 1'b0;
`endif

  assign d1_d = wr_en ? ((RDW_MODE != 0) ? merged : rd_word) : '0;
  assign v1_d = access;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d1_q <= '0;
      v1_q <= 1'b0;
      p1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= v1_d;
      p1_q <= p1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] d2_q;
      logic          v2_q;
      logic          p2_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          d2_q <= '0;
          v2_q <= 1'b0;
          p2_q <= 1'b0;
        end else begin
          d2_q <= d1_q;
          v2_q <= v1_q;
          p2_q <= p1_q;
        end
      end

      assign bus.Do    = d2_q;
      assign bus.VALID = v2_q;
      assign bus.PERR  = p2_q;
    end else begin : g_noreg
      assign bus.Do    = d1_q;
      assign bus.VALID = v1_q;
      assign bus.PERR  = p1_q;
    end
  endgenerate

  assign bus.READY = ready;
endmodule

// File: tb/tb_dffram_rtl_param.sv
// Bench for dffram_rtl_param: two instances (latency 1 / old-data, latency 2 / new-data)
// driven identically and checked every cycle against a word-array reference model.
module tb_dffram_rtl_param;
  localparam int WORDS = 20;
  localparam int NB    = 4;
  localparam int AW    = $clog2(WORDS);
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  dffram_rtl_param_if #(.NB(NB), .A_WIDTH(AW)) b0 ();
  dffram_rtl_param_if #(.NB(NB), .A_WIDTH(AW)) b1 ();

  dffram_rtl_param #(.WORDS(WORDS), .NB(NB), .OUT_REG(0), .RDW_MODE(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(b0.slave));
  dffram_rtl_param #(.WORDS(WORDS), .NB(NB), .OUT_REG(1), .RDW_MODE(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(b1.slave));

  logic          en_r, clr_r, pinj_r;
  logic [NB-1:0] we_r;
  logic [AW-1:0] a_r;
  logic [31:0]   di_r;

  assign b0.EN = en_r;  assign b0.WE = we_r;  assign b0.A = a_r;
  assign b0.Di = di_r;  assign b0.CLR = clr_r; assign b0.PINJ = pinj_r;
  assign b1.EN = en_r;  assign b1.WE = we_r;  assign b1.A = a_r;
  assign b1.Di = di_r;  assign b1.CLR = clr_r; assign b1.PINJ = pinj_r;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: plain word array plus a per-byte "stored parity is bad" flag.
  logic [31:0]   mem_m [WORDS];
  logic [NB-1:0] bad_m [WORDS];
  bit            rdy_m;
  int            fill_left;
  logic [31:0]   e_do0, e_do1, s1_do1;
  bit            e_v0, e_v1, s1_v1, e_p0, e_p1, s1_p1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rdy_m = 1'b0; fill_left = WORDS;
    e_do0 = '0; e_v0 = 1'b0; e_p0 = 1'b0;
    e_do1 = '0; e_v1 = 1'b0; e_p1 = 1'b0;
    s1_do1 = '0; s1_v1 = 1'b0; s1_p1 = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0]   old_w, mrg;
    logic [NB-1:0] ob, mb;
    bit            acc;
    acc = rdy_m && en_r;
    e_do1 = s1_do1; e_v1 = s1_v1; e_p1 = s1_p1;
    e_do0 = '0; e_v0 = acc; e_p0 = 1'b0;
    s1_do1 = '0; s1_v1 = acc; s1_p1 = 1'b0;
    if (acc && (int'(a_r) < WORDS)) begin
      old_w = mem_m[a_r]; ob = bad_m[a_r];
      mrg = old_w; mb = ob;
      for (int i = 0; i < NB; i++) begin
        if (we_r[i]) begin
          mrg[8*i +: 8] = di_r[8*i +: 8];
          mb[i] = pinj_r;
        end
      end
      e_do0 = old_w;  e_p0 = PAR && (|ob);
      s1_do1 = mrg;   s1_p1 = PAR && (|mb);
      mem_m[a_r] = mrg; bad_m[a_r] = mb;
    end
    if (rdy_m) begin
      if (clr_r) begin rdy_m = 1'b0; fill_left = WORDS; end
    end else if (clr_r) begin
      fill_left = WORDS;
    end else begin
      fill_left--;
      if (fill_left == 0) begin
        rdy_m = 1'b1;
        for (int w = 0; w < WORDS; w++) begin mem_m[w] = '0; bad_m[w] = '0; end
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ready0", b0.READY, rdy_m);
      chk("valid0", b0.VALID, e_v0);
      chk("do0",    b0.Do,    e_do0);
      chk("perr0",  b0.PERR,  e_p0);
      chk("ready1", b1.READY, rdy_m);
      chk("valid1", b1.VALID, e_v1);
      chk("do1",    b1.Do,    e_do1);
      chk("perr1",  b1.PERR,  e_p1);
    end
  end

  task automatic drive(input bit en, input logic [NB-1:0] we, input logic [AW-1:0] a,
                       input logic [31:0] di, input bit clr, input bit pinj);
    en_r = en; we_r = we; a_r = a; di_r = di; clr_r = clr; pinj_r = pinj;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_update();
    #1;
  endtask

  task automatic count_fill(input string nm);
    int n;
    bit any_v;
    n = 0; any_v = 1'b0;
    while (!b0.READY && n < 4 * WORDS) begin
      drive(1'($urandom_range(0, 1)), NB'($urandom), AW'($urandom_range(0, WORDS - 1)),
            $urandom, 1'b0, 1'b0);
      step();
      n++;
      any_v |= b0.VALID;
    end
    chk(nm, n, WORDS);
    chk({nm, "_novalid"}, any_v, 1'b0);
    idle();
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    model_reset();
    step();
    chk_en = 1'b1;
    step(); step();
    chk("rst_ready", b0.READY, 1'b0);
    chk("rst_valid", b0.VALID, 1'b0);
    chk("rst_do",    b0.Do,    32'h0);

    RST_N = 1'b1;
    count_fill("fill_cycles");

    drive(1'b1, '0, AW'(0), '0, 1'b0, 1'b0); step();
    chk("rd0_valid", b0.VALID, 1'b1); chk("rd0_do", b0.Do, 32'h0);
    drive(1'b1, '0, AW'(5), '0, 1'b0, 1'b0); step();
    chk("rd5_valid", b0.VALID, 1'b1); chk("rd5_do", b0.Do, 32'h0);
    drive(1'b1, '0, AW'(WORDS - 1), '0, 1'b0, 1'b0); step();
    chk("rdlast_valid", b0.VALID, 1'b1); chk("rdlast_do", b0.Do, 32'h0);

    drive(1'b1, 4'b0101, AW'(3), 32'hDEADBEEF, 1'b0, 1'b0); step();
    drive(1'b1, 4'b0000, AW'(3), 32'h0, 1'b0, 1'b0); step();
    chk("bytewr_lat1", b0.Do, 32'h00AD00EF);
    idle(); step();
    chk("bytewr_lat2", b1.Do, 32'h00AD00EF);
    chk("bytewr_lat2_v", b1.VALID, 1'b1);

    drive(1'b1, 4'hF, AW'(7), 32'h11223344, 1'b0, 1'b0); step();
    drive(1'b1, 4'hF, AW'(7), 32'hAABBCCDD, 1'b0, 1'b0); step();
    chk("rdw_old", b0.Do, 32'h11223344);
    drive(1'b1, 4'h0, AW'(7), 32'h0, 1'b0, 1'b0); step();
    chk("rdw_after", b0.Do, 32'hAABBCCDD);
    chk("rdw_new", b1.Do, 32'hAABBCCDD);

    drive(1'b1, 4'h0, AW'(25), 32'h0, 1'b0, 1'b0); step();
    chk("oor_valid", b0.VALID, 1'b1); chk("oor_do", b0.Do, 32'h0);

    drive(1'b1, 4'hF, AW'(9), 32'h5A5A0F0F, 1'b0, 1'b1); step();
    drive(1'b1, 4'h0, AW'(9), 32'h0, 1'b0, 1'b0); step();
    chk("par_inj", b0.PERR, PAR); chk("par_inj_v", b0.VALID, 1'b1);
    drive(1'b1, 4'hF, AW'(9), 32'h5A5A0F0F, 1'b0, 1'b0); step();
    drive(1'b1, 4'h0, AW'(9), 32'h0, 1'b0, 1'b0); step();
    chk("par_clean", b0.PERR, 1'b0);

    idle();
    clr_r = 1'b1; step(); clr_r = 1'b0;
    chk("clr_ready", b0.READY, 1'b0);
    count_fill("clr_fill_cycles");
    drive(1'b1, '0, AW'(3), '0, 1'b0, 1'b0); step();
    chk("clr_rd3", b0.Do, 32'h0);
    drive(1'b1, '0, AW'(7), '0, 1'b0, 1'b0); step();
    chk("clr_rd7", b0.Do, 32'h0);

    idle();
    clr_r = 1'b1; step(); clr_r = 1'b0;
    for (int k = 0; k < WORDS / 2; k++) step();
    RST_N = 1'b0; model_reset();
    step(); step();
    RST_N = 1'b1;
    count_fill("midfill_rst_cycles");

    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? NB'(0) : NB'($urandom),
            ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 3) == 0));
      step();
    end
    idle(); step(); step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
